cn_engine: RTL and testbench

Parametrised, sequential successor to the combinational CN datapath. It accepts NUM_CH input codes serially over a valid/ready stream and maps each code through a run-time-writable lookup table. It then applies an opcode-selected reduction (sum, max, min, range) or a sort, and returns the result over a valid/ready output stream. It sits between the pattern/stimulus front end and the result checker, and replaces the fixed six-input CN.

---
 rtl/cn_engine.sv | 209 ++++++++++++++++++++
 tb/tb_cn_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cn_engine.sv
`default_nettype none
// ============================================================================
//  Module   : cn_engine
//  Brief    : Serial code-to-value LUT mapper with sum/max/min/range reduction
//             or odd-even transposition sort, valid/ready in and out.
//  Revision : 1.0  initial release
// ============================================================================
module cn_engine #(
   parameter int NUM_CH = 6,
   parameter int IN_W   = 4,
   parameter int LUT_W  = 5,
   parameter int OUT_W  = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lut_we,
   input  logic [IN_W-1:0]  lut_waddr,
   input  logic [LUT_W-1:0] lut_wdata,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [2:0]       in_opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last
);

   localparam int c_depth = 1 << IN_W;
   localparam int c_cnt_w = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_CH - 1);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_SORT = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   function automatic logic [LUT_W-1:0] lut_rst(input int idx);
      int v;
      if (IN_W == 4) begin
         case (idx)
            0: v = 9;   1: v = 27;  2: v = 30;  3: v = 3;
            4: v = 11;  5: v = 8;   6: v = 26;  7: v = 17;
            8: v = 3;   9: v = 12;  10: v = 1;  11: v = 10;
            12: v = 15; 13: v = 5;  14: v = 23; default: v = 20;
         endcase
      end else begin
         v = idx % (1 << LUT_W);
      end
      return LUT_W'(v);
   endfunction

   state_t               r_state;
   state_t               w_state_n;
   logic [LUT_W-1:0]     r_lut  [c_depth];
   logic [LUT_W-1:0]     r_slot [NUM_CH];
   logic [LUT_W-1:0]     w_sorted [NUM_CH];
   logic [c_cnt_w-1:0]   r_cnt;
   logic [c_cnt_w-1:0]   r_scnt;
   logic [c_cnt_w-1:0]   r_oidx;
   logic [c_cnt_w-1:0]   w_oidx_n;
   logic [2:0]           r_op;
   logic [OUT_W-1:0]     r_sum;
   logic [LUT_W-1:0]     r_max;
   logic [LUT_W-1:0]     r_min;
   logic [OUT_W-1:0]     w_sum_n;
   logic [LUT_W-1:0]     w_max_n;
   logic [LUT_W-1:0]     w_min_n;
   logic [LUT_W-1:0]     w_lut_val;
   logic [OUT_W-1:0]     w_scalar;
   logic                 w_in_fire;
   logic                 w_is_sort;
   logic                 w_desc;
   logic                 r_out_valid;
   logic                 r_out_last;
   logic [OUT_W-1:0]     r_out_data;

   assign in_ready  = (r_state == S_LOAD);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;

   // Combinational read returns the pre-write value when a write hits the same cycle
   assign w_in_fire = in_valid && (r_state == S_LOAD);
   assign w_lut_val = r_lut[in_data];
   assign w_sum_n   = r_sum + OUT_W'(w_lut_val);
   assign w_max_n   = (w_lut_val > r_max) ? w_lut_val : r_max;
   assign w_min_n   = (w_lut_val < r_min) ? w_lut_val : r_min;
   assign w_is_sort = (r_op == 3'd4) || (r_op == 3'd5);
   assign w_desc    = (r_op == 3'd5);
   assign w_oidx_n  = r_oidx + 1'b1;

   always_comb begin
      w_scalar = '0;
      case (r_op)
         3'd0:    w_scalar = w_sum_n;
         3'd1:    w_scalar = OUT_W'(w_max_n);
         3'd2:    w_scalar = OUT_W'(w_min_n);
         3'd3:    w_scalar = OUT_W'(w_max_n - w_min_n);
         default: w_scalar = '0;
      endcase
   end

   // One transposition pass: even pairs on even steps, odd pairs on odd steps
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) w_sorted[i] = r_slot[i];
      for (int i = 0; i + 1 < NUM_CH; i++) begin
         if (i[0] == r_scnt[0]) begin
            if (w_desc ? (r_slot[i] < r_slot[i+1]) : (r_slot[i] > r_slot[i+1])) begin
               w_sorted[i]   = r_slot[i+1];
               w_sorted[i+1] = r_slot[i];
            end
         end
      end
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_LOAD: if (w_in_fire && (r_cnt == c_last)) w_state_n = w_is_sort ? S_SORT : S_OUT;
         S_SORT: if (r_scnt == c_last) w_state_n = S_OUT;
         S_OUT:  if (out_ready && r_out_last) w_state_n = S_LOAD;
         default: w_state_n = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_LOAD;
      else        r_state <= w_state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_depth; i++) r_lut[i] <= lut_rst(i);
      end else if (lut_we) begin
         r_lut[lut_waddr] <= lut_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) r_slot[i] <= '0;
         r_cnt       <= '0;
         r_scnt      <= '0;
         r_oidx      <= '0;
         r_op        <= '0;
         r_sum       <= '0;
         r_max       <= '0;
         r_min       <= '1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else begin
         r_out_valid <= (w_state_n == S_OUT);
         case (r_state)
            S_LOAD: begin
               if (w_in_fire) begin
                  r_slot[r_cnt] <= w_lut_val;
                  if (r_cnt == '0) r_op <= in_opcode;
                  if (r_cnt == c_last) begin
                     // Result is captured now, so accumulators restart for the next op
                     r_cnt  <= '0;
                     r_sum  <= '0;
                     r_max  <= '0;
                     r_min  <= '1;
                     r_scnt <= '0;
                     r_oidx <= '0;
                     if (!w_is_sort) begin
                        r_out_data <= w_scalar;
                        r_out_last <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                     r_sum <= w_sum_n;
                     r_max <= w_max_n;
                     r_min <= w_min_n;
                  end
               end
            end
            S_SORT: begin
               for (int i = 0; i < NUM_CH; i++) r_slot[i] <= w_sorted[i];
               r_scnt <= r_scnt + 1'b1;
               if (r_scnt == c_last) begin
                  r_scnt     <= '0;
                  r_oidx     <= '0;
                  r_out_data <= OUT_W'(w_sorted[0]);
                  r_out_last <= 1'b0;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  if (r_out_last) begin
                     r_out_last <= 1'b0;
                     r_oidx     <= '0;
                  end else begin
                     r_oidx     <= w_oidx_n;
                     r_out_data <= OUT_W'(r_slot[w_oidx_n]);
                     r_out_last <= (w_oidx_n == c_last);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cn_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cn_engine
//  Brief    : Directed self-checking bench for cn_engine at default parameters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cn_engine;

   logic       clk;
   logic       rst_n;
   logic       lut_we;
   logic [3:0] lut_waddr;
   logic [4:0] lut_wdata;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic [2:0] in_opcode;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_data;
   logic       out_last;

   int total = 0;
   int bad   = 0;

   logic [3:0] codes [6];
   int         expv  [6];
   int         wr_beat;
   logic [3:0] wr_addr;
   logic [4:0] wr_data;

   cn_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lut_we    (lut_we),
      .lut_waddr (lut_waddr),
      .lut_wdata (lut_wdata),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_opcode (in_opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Later beats carry opcode 7 so a design latching past beat 0 is exposed
   task automatic send(input logic [2:0] op, input int gap);
      for (int i = 0; i < 6; i++) begin
         int w = 0;
         in_valid  = 1'b1;
         in_data   = codes[i];
         in_opcode = (i == 0) ? op : 3'd7;
         if (i == wr_beat) begin
            lut_we    = 1'b1;
            lut_waddr = wr_addr;
            lut_wdata = wr_data;
         end
         while (!in_ready && w < 100) begin
            tick();
            w++;
         end
         if (w == 100) check("in_ready_timeout", 0, 1);
         tick();
         in_valid = 1'b0;
         lut_we   = 1'b0;
         if (i < 5) repeat (gap) tick();
      end
   endtask

   task automatic wait_out(input string tag, input int lat);
      int k = 0;
      while (!out_valid && k < 50) begin
         tick();
         k++;
      end
      check($sformatf("%s_lat", tag), k, lat);
   endtask

   task automatic recv(input string tag, input int nbeats, input int lat);
      wait_out(tag, lat);
      for (int b = 0; b < nbeats; b++) begin
         check($sformatf("%s_d%0d", tag, b), int'(out_data), expv[b]);
         check($sformatf("%s_l%0d", tag, b), int'(out_last), (b == nbeats - 1) ? 1 : 0);
         check($sformatf("%s_ir%0d", tag, b), int'(in_ready), 0);
         tick();
      end
      check($sformatf("%s_done_ov", tag), int'(out_valid), 0);
      check($sformatf("%s_done_ir", tag), int'(in_ready), 1);
   endtask

   task automatic set_codes(input int a, input int b, input int c,
                            input int d, input int e, input int f);
      codes[0] = 4'(a); codes[1] = 4'(b); codes[2] = 4'(c);
      codes[3] = 4'(d); codes[4] = 4'(e); codes[5] = 4'(f);
   endtask

   task automatic set_exp(input int a, input int b, input int c,
                          input int d, input int e, input int f);
      expv[0] = a; expv[1] = b; expv[2] = c;
      expv[3] = d; expv[4] = e; expv[5] = f;
   endtask

   initial begin
      rst_n = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
      in_valid = 1'b0; in_data = '0; in_opcode = '0; out_ready = 1'b1;
      wr_beat = -1; wr_addr = '0; wr_data = '0;
      repeat (3) tick();
      check("rst_in_ready",  int'(in_ready),  1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data",  int'(out_data),  0);
      check("rst_out_last",  int'(out_last),  0);
      rst_n = 1'b1;
      tick();

      // Scalar reductions on codes 0..5 -> values 9,27,30,3,11,8
      set_codes(0, 1, 2, 3, 4, 5);
      set_exp(88, 0, 0, 0, 0, 0); send(3'd0, 0); recv("sum", 1, 0);
      set_exp(30, 0, 0, 0, 0, 0); send(3'd1, 0); recv("max", 1, 0);
      set_exp(3, 0, 0, 0, 0, 0);  send(3'd2, 0); recv("min", 1, 0);
      set_exp(27, 0, 0, 0, 0, 0); send(3'd3, 0); recv("rng", 1, 0);
      set_exp(0, 0, 0, 0, 0, 0);  send(3'd6, 0); recv("rsv", 1, 0);

      set_exp(3, 8, 9, 11, 27, 30); send(3'd4, 0); recv("asc", 6, 6);
      set_exp(30, 27, 11, 9, 8, 3); send(3'd5, 0); recv("desc", 6, 6);

      // Duplicates: 3,8,3,8,10,10 -> 3,3,3,3,1,1
      set_codes(3, 8, 3, 8, 10, 10);
      set_exp(1, 1, 3, 3, 3, 3); send(3'd4, 0); recv("dup", 6, 6);
      set_codes(15, 15, 15, 15, 15, 15);
      set_exp(120, 0, 0, 0, 0, 0); send(3'd0, 0); recv("sum15", 1, 0);

      // LUT write then full-scale sum
      lut_we = 1'b1; lut_waddr = 4'd0; lut_wdata = 5'd31;
      tick();
      lut_we = 1'b0;
      set_codes(0, 0, 0, 0, 0, 0);
      set_exp(186, 0, 0, 0, 0, 0); send(3'd0, 0); recv("sum31", 1, 0);

      // Same-cycle write to addr 1 must not affect that beat: 31+27+30+3+11+8
      set_codes(0, 1, 2, 3, 4, 5);
      wr_beat = 1; wr_addr = 4'd1; wr_data = 5'd0;
      set_exp(110, 0, 0, 0, 0, 0); send(3'd0, 0); recv("wrsame", 1, 0);
      wr_beat = -1;
      set_codes(1, 1, 1, 1, 1, 1);
      set_exp(0, 0, 0, 0, 0, 0); send(3'd1, 0); recv("wrnew", 1, 0);

      // Irregular input gaps on codes 2..7 -> 30,3,11,8,26,17
      set_codes(2, 3, 4, 5, 6, 7);
      set_exp(30, 0, 0, 0, 0, 0); send(3'd1, 2); recv("gapmax", 1, 0);

      // Backpressure mid sort output
      set_exp(3, 8, 11, 17, 26, 30);
      send(3'd4, 1);
      wait_out("bp", 6);
      for (int b = 0; b < 6; b++) begin
         if (b == 2) begin
            out_ready = 1'b0;
            for (int h = 0; h < 5; h++) begin
               tick();
               check($sformatf("bp_hold_d%0d", h), int'(out_data), expv[2]);
               check($sformatf("bp_hold_l%0d", h), int'(out_last), 0);
               check($sformatf("bp_hold_v%0d", h), int'(out_valid), 1);
               check($sformatf("bp_hold_ir%0d", h), int'(in_ready), 0);
            end
            out_ready = 1'b1;
         end
         check($sformatf("bp_d%0d", b), int'(out_data), expv[b]);
         check($sformatf("bp_l%0d", b), int'(out_last), (b == 5) ? 1 : 0);
         tick();
      end
      check("bp_done_ir", int'(in_ready), 1);

      // Reset during SORT aborts and restores the LUT
      set_codes(0, 1, 2, 3, 4, 5);
      send(3'd4, 0);
      tick();
      tick();
      check("mid_ir_sort", int'(in_ready), 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ov", int'(out_valid), 0);
      check("mid_rst_ir", int'(in_ready),  1);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         check($sformatf("post_rst_ov%0d", c), int'(out_valid), 0);
      end
      check("post_rst_ir", int'(in_ready), 1);
      set_exp(88, 0, 0, 0, 0, 0); send(3'd0, 0); recv("post_rst_sum", 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
